// File: rtl/i281_multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the i281 datapath.
// Optional single-step start when I281_STEP_EN is defined.
module i281_multicycle_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   input  logic             step,
   input  logic [3:0]       opcode,
   input  logic             br_taken,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic             rf_we,
   output logic             flag_we,
   output logic             dmem_we,
   output logic             dmem_src,
   output logic [2:0]       state,
   output logic             busy,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_t;

   localparam logic [3:0] OP_NOOP   = 4'b0000;
   localparam logic [3:0] OP_INPUT  = 4'b0001;
   localparam logic [3:0] OP_MOVE   = 4'b0010;
   localparam logic [3:0] OP_LOADI  = 4'b0011;
   localparam logic [3:0] OP_ADD    = 4'b0100;
   localparam logic [3:0] OP_ADDI   = 4'b0101;
   localparam logic [3:0] OP_SUB    = 4'b0110;
   localparam logic [3:0] OP_SUBI   = 4'b0111;
   localparam logic [3:0] OP_LOAD   = 4'b1000;
   localparam logic [3:0] OP_LOADF  = 4'b1001;
   localparam logic [3:0] OP_STORE  = 4'b1010;
   localparam logic [3:0] OP_STOREF = 4'b1011;
   localparam logic [3:0] OP_SHIFT  = 4'b1100;
   localparam logic [3:0] OP_CMP    = 4'b1101;
   localparam logic [3:0] OP_JUMP   = 4'b1110;
   localparam logic [3:0] OP_BRANCH = 4'b1111;

   state_t           state_reg;
   state_t           state_next;
   logic             busy_reg;
   logic [CNT_W-1:0] retired_reg;
   logic             instr_end;
   logic             start;

   logic is_flag;
   logic is_wb;
   logic is_load;
   logic is_store;
   logic is_input;
   logic is_jump;
   logic is_branch;

   // Any opcode not listed (including X in simulation) falls to default and behaves as NOOP.
   always_comb begin
      is_flag   = 1'b0;
      is_wb     = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_input  = 1'b0;
      is_jump   = 1'b0;
      is_branch = 1'b0;
      case (opcode)
         OP_INPUT:                       is_input  = 1'b1;
         OP_MOVE, OP_LOADI:              is_wb     = 1'b1;
         OP_ADD, OP_ADDI, OP_SUB, OP_SUBI,
         OP_SHIFT: begin
            is_wb   = 1'b1;
            is_flag = 1'b1;
         end
         OP_CMP:                         is_flag   = 1'b1;
         OP_LOAD, OP_LOADF:              is_load   = 1'b1;
         OP_STORE, OP_STOREF:            is_store  = 1'b1;
         OP_JUMP:                        is_jump   = 1'b1;
         OP_BRANCH:                      is_branch = 1'b1;
         OP_NOOP:                        is_wb     = 1'b0;
         default:                        is_wb     = 1'b0;
      endcase
   end

`ifdef I281_STEP_EN
   logic step_prev;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) step_prev <= 1'b0;
      else        step_prev <= step;
   end

   // Only consulted in IDLE, so rising edges seen while busy are dropped.
   assign start = run | (step & ~step_prev);
`else
   logic unused_step;
   assign unused_step = step;
   assign start       = run;
`endif

   always_comb begin
      state_next = state_reg;
      instr_end  = 1'b0;
      case (state_reg)
         S_IDLE:   if (start) state_next = S_FETCH;
         S_FETCH:  state_next = S_DECODE;
         S_DECODE: state_next = S_EXEC;
         S_EXEC: begin
            if (is_load || is_store || is_input) state_next = S_MEM;
            else if (is_wb)                      state_next = S_WB;
            else                                 instr_end  = 1'b1;
         end
         S_MEM: begin
            if (is_load) state_next = S_WB;
            else         instr_end  = 1'b1;
         end
         S_WB:     instr_end  = 1'b1;
         default:  state_next = S_IDLE;
      endcase
      // run is sampled only at instruction boundaries, never mid-instruction.
      if (instr_end) state_next = run ? S_FETCH : S_IDLE;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg   <= S_IDLE;
         busy_reg    <= 1'b0;
         retired_reg <= '0;
      end else begin
         state_reg <= state_next;
         busy_reg  <= (state_next != S_IDLE);
         if (instr_end) retired_reg <= retired_reg + CNT_W'(1);
      end
   end

   // Strobes decode from the registered state so an async reset clears them at once.
   always_comb begin
      ir_we    = (state_reg == S_FETCH);
      pc_sel   = (state_reg == S_EXEC) && (is_jump || (is_branch && br_taken));
      pc_we    = (state_reg == S_FETCH) || pc_sel;
      rf_we    = (state_reg == S_WB);
      flag_we  = (state_reg == S_EXEC) && is_flag;
      dmem_we  = (state_reg == S_MEM) && (is_store || is_input);
      dmem_src = (state_reg == S_MEM) && is_input;
   end

   assign state   = state_reg;
   assign busy    = busy_reg;
   assign retired = retired_reg;

endmodule
